// File: rtl/sme_pkg.sv
// Shared definitions for the string-match engine (SME) datapath.
// Holds the character constants, the size parameters and the FSM state
// type used by the core, its comparator and its bus interface.
package sme_pkg;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int DW      = 8;
    localparam int IDX_W   = $clog2(STR_MAX);

    typedef logic [DW-1:0] char_t;

    localparam char_t CH_SPACE  = 8'h20;
    localparam char_t CH_DOT    = 8'h2E;
    localparam char_t CH_CARET  = 8'h5E;
    localparam char_t CH_DOLLAR = 8'h24;
    localparam char_t CH_STAR   = 8'h2A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_S = 2'd1,
        LOAD_P = 2'd2,
        SCAN   = 2'd3
    } sme_state_t;

endpackage

// File: rtl/str_match_core_if.sv
// Character-stream input and match-report output bundle of str_match_core.
//   isstring/ispattern/chardata : character strobes from the upstream feeder
//   match_v/m_done/m_idx/head20/head2e : result pulses to the index-send stage
//   star_pat : level flag telling the star engine the pattern holds '*'
// master = feeder + index-send side, slave = the match core.
interface str_match_core_if;
    import sme_pkg::*;

    logic              isstring;
    logic              ispattern;
    char_t             chardata;
    logic              match_v;
    logic              m_done;
    logic [IDX_W-1:0]  m_idx;
    logic              head20;
    logic              head2e;
    logic              star_pat;

    modport master (
        output isstring, ispattern, chardata,
        input  match_v, m_done, m_idx, head20, head2e, star_pat
    );

    modport slave (
        input  isstring, ispattern, chardata,
        output match_v, m_done, m_idx, head20, head2e, star_pat
    );

endinterface

// File: rtl/sme_pat_cmp.sv
// Combinational body comparator: does the pattern body match the buffered
// string starting at offset i_b, and (when i_tail) is the '$' anchor met?
//   i_str/i_slen : buffered string and its length (0..32)
//   i_body/i_blen: pattern body (anchors stripped) and its length (0..8)
//   i_b          : candidate offset (0..32)
//   i_tail       : pattern ends with '$'
//   o_hit        : body and tail anchor both satisfied
module sme_pat_cmp
    import sme_pkg::*;
(
    input  char_t       i_str  [STR_MAX],
    input  logic [5:0]  i_slen,
    input  char_t       i_body [PAT_MAX],
    input  logic [3:0]  i_blen,
    input  logic [5:0]  i_b,
    input  logic        i_tail,
    output logic        o_hit
);

    logic [5:0] w_idx;
    logic [5:0] w_e;
    logic       w_body_ok;
    logic       w_dollar_ok;

    // 6-bit sums so an offset running past the string end is caught, not wrapped
    assign w_e = i_b + {2'b00, i_blen};

    // Per-character body compare; '.' matches any character
    always_comb begin
        w_body_ok = 1'b1;
        w_idx     = 6'd0;
        for (int k = 0; k < PAT_MAX; k++) begin
            w_idx = i_b + 6'(k);
            if (4'(k) < i_blen) begin
                if (w_idx >= i_slen) begin
                    w_body_ok = 1'b0;
                end else if ((i_body[k] != CH_DOT) && (i_str[w_idx[4:0]] != i_body[k])) begin
                    w_body_ok = 1'b0;
                end else begin
                    w_body_ok = w_body_ok;
                end
            end else begin
                w_body_ok = w_body_ok;
            end
        end
    end

    // '$' is satisfied at the string end or in front of a space
    always_comb begin
        if (!i_tail) begin
            w_dollar_ok = 1'b1;
        end else if (w_e == i_slen) begin
            w_dollar_ok = 1'b1;
        end else if (w_e < i_slen) begin
            w_dollar_ok = (i_str[w_e[4:0]] == CH_SPACE);
        end else begin
            w_dollar_ok = 1'b0;
        end
    end

    assign o_hit = w_body_ok && w_dollar_ok;

endmodule

// File: rtl/str_match_core.sv
// Literal/anchored string-match engine. Buffers one string (<=32 chars) and
// one pattern (<=8 chars), then scans one candidate start per cycle and
// reports the first match (match_v + m_idx/head20/head2e) or exhaustion
// (m_done). Patterns containing '*' are flagged on star_pat and not scanned.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : str_match_core_if slave modport (strobes in, results out)
module str_match_core
    import sme_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    str_match_core_if.slave    bus
);

    sme_state_t        r_state;
    char_t             r_str [STR_MAX];
    char_t             r_pat [PAT_MAX];
    logic [5:0]        r_slen;
    logic [3:0]        r_plen;
    logic [IDX_W-1:0]  r_s;
    logic              r_match_v;
    logic              r_m_done;
    logic [IDX_W-1:0]  r_m_idx;
    logic              r_head20;
    logic              r_head2e;
    logic              r_star_pat;

    logic              w_lead;
    logic              w_tail;
    logic [3:0]        w_blen;
    char_t             w_body [PAT_MAX];
    logic [5:0]        w_b0;
    logic [5:0]        w_b1;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_hit_n;
    logic              w_last;

    // r_plen[2:0]-1 wraps to 7 when plen==8, which is the last stored char
    assign w_lead = (r_plen != 4'd0) && (r_pat[0] == CH_CARET);
    assign w_tail = (r_plen != 4'd0) && (r_pat[r_plen[2:0] - 3'd1] == CH_DOLLAR);
    assign w_blen = r_plen - {3'b000, w_lead} - {3'b000, w_tail};

    // Body = pattern shifted past a leading '^'; trailing '$' is excluded by w_blen
    always_comb begin
        for (int k = 0; k < PAT_MAX; k++) begin
            if (w_lead) begin
                if (k < PAT_MAX - 1) begin
                    w_body[k] = r_pat[k + 1];
                end else begin
                    w_body[k] = 8'h00;
                end
            end else begin
                w_body[k] = r_pat[k];
            end
        end
    end

    assign w_b0 = {1'b0, r_s};
    assign w_b1 = w_b0 + 6'd1;

    sme_pat_cmp u_cmp_s (
        .i_str  (r_str),
        .i_slen (r_slen),
        .i_body (w_body),
        .i_blen (w_blen),
        .i_b    (w_b0),
        .i_tail (w_tail),
        .o_hit  (w_hit0)
    );

    // Offset s+1 serves the "space then body" form of the '^' anchor
    sme_pat_cmp u_cmp_s1 (
        .i_str  (r_str),
        .i_slen (r_slen),
        .i_body (w_body),
        .i_blen (w_blen),
        .i_b    (w_b1),
        .i_tail (w_tail),
        .o_hit  (w_hit1)
    );

    assign w_hit_a = w_lead && (r_s == 5'd0) && w_hit0;
    assign w_hit_b = w_lead && (r_str[r_s] == CH_SPACE) && w_hit1;
    assign w_hit_n = !w_lead && w_hit0;
    assign w_last  = (w_b0 == (r_slen - 6'd1));

    // Load/scan FSM with registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_slen     <= 6'd0;
            r_plen     <= 4'd0;
            r_s        <= 5'd0;
            r_match_v  <= 1'b0;
            r_m_done   <= 1'b0;
            r_m_idx    <= 5'd0;
            r_head20   <= 1'b0;
            r_head2e   <= 1'b0;
            r_star_pat <= 1'b0;
        end else begin
            r_match_v <= 1'b0;
            r_m_done  <= 1'b0;
            if (bus.isstring) begin
                // isstring outranks ispattern; a strobe also aborts any scan
                if (r_state != LOAD_S) begin
                    r_str[0] <= bus.chardata;
                    r_slen   <= 6'd1;
                end else if (r_slen < 6'd32) begin
                    r_str[r_slen[4:0]] <= bus.chardata;
                    r_slen             <= r_slen + 6'd1;
                end
                r_state <= LOAD_S;
            end else if (bus.ispattern) begin
                if (r_state != LOAD_P) begin
                    r_pat[0]   <= bus.chardata;
                    r_plen     <= 4'd1;
                    r_star_pat <= (bus.chardata == CH_STAR);
                end else begin
                    if (r_plen < 4'd8) begin
                        r_pat[r_plen[2:0]] <= bus.chardata;
                        r_plen             <= r_plen + 4'd1;
                    end
                    if (bus.chardata == CH_STAR) begin
                        r_star_pat <= 1'b1;
                    end
                end
                r_state <= LOAD_P;
            end else begin
                case (r_state)
                    LOAD_S: begin
                        r_state <= IDLE;
                    end
                    LOAD_P: begin
                        r_s     <= 5'd0;
                        r_state <= r_star_pat ? IDLE : SCAN;
                    end
                    SCAN: begin
                        if (r_slen == 6'd0) begin
                            r_m_done <= 1'b1;
                            r_m_idx  <= 5'd0;
                            r_head20 <= 1'b0;
                            r_head2e <= 1'b0;
                            r_state  <= IDLE;
                        end else if (w_hit_a) begin
                            r_match_v <= 1'b1;
                            r_m_idx   <= 5'd0;
                            r_head20  <= 1'b0;
                            r_head2e  <= 1'b1;
                            r_state   <= IDLE;
                        end else if (w_hit_b || w_hit_n) begin
                            r_match_v <= 1'b1;
                            r_m_idx   <= r_s + 5'd1;
                            r_head20  <= w_hit_b;
                            r_head2e  <= 1'b0;
                            r_state   <= IDLE;
                        end else if (w_last) begin
                            r_m_done <= 1'b1;
                            r_m_idx  <= 5'd0;
                            r_head20 <= 1'b0;
                            r_head2e <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.match_v  = r_match_v;
    assign bus.m_done   = r_m_done;
    assign bus.m_idx    = r_m_idx;
    assign bus.head20   = r_head20;
    assign bus.head2e   = r_head2e;
    assign bus.star_pat = r_star_pat;

endmodule

// File: tb/tb_str_match_core.sv
// Scoreboard bench for str_match_core: the driver loads strings/patterns,
// a string-level reference model predicts the result pulse and its cycle,
// and a negedge monitor pops and compares each pulse.
module tb_str_match_core;

    typedef byte bq_t[$];
    typedef struct {
        bit hit;
        int idx;
        bit h20;
        bit h2e;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    bq_t  cur_str;
    logic [4:0] hold_idx = 5'd0;
    bit   hold_h20 = 1'b0;
    bit   hold_h2e = 1'b0;

    str_match_core_if bus ();

    str_match_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(byte'(s[i]));
        return q;
    endfunction

    // Does body bd sit at offset b of st, honouring '.' and an optional '$'
    function automatic bit body_at(input bq_t st, input bq_t bd, input bit tl, input int b);
        int n;
        int e;
        n = st.size();
        for (int k = 0; k < bd.size(); k++) begin
            if (b + k >= n) return 1'b0;
            if (bd[k] != 8'h2E && st[b + k] != bd[k]) return 1'b0;
        end
        if (tl) begin
            e = b + bd.size();
            if (!(e == n || (e < n && st[e] == 8'h20))) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference: first matching candidate, or exhaustion; s = deciding candidate
    task automatic model(input bq_t sq, input bq_t pq, output bit star, output exp_t r, output int s_dec);
        bq_t st;
        bq_t pt;
        bq_t bd;
        bit lead;
        bit tail;
        int n;
        st = sq;
        pt = pq;
        star = 1'b0;
        foreach (pq[i]) if (pq[i] == 8'h2A) star = 1'b1;
        while (st.size() > 32) void'(st.pop_back());
        while (pt.size() > 8) void'(pt.pop_back());
        n = st.size();
        lead = (pt.size() > 0) && (pt[0] == 8'h5E);
        tail = (pt.size() > 0) && (pt[pt.size() - 1] == 8'h24);
        for (int i = (lead ? 1 : 0); i < pt.size() - (tail ? 1 : 0); i++) bd.push_back(pt[i]);
        r = '{hit: 1'b0, idx: 0, h20: 1'b0, h2e: 1'b0, cyc: 0};
        s_dec = (n > 0) ? n - 1 : 0;
        for (int s = 0; s < n && !r.hit; s++) begin
            if (!lead) begin
                if (body_at(st, bd, tail, s)) begin
                    r.hit = 1'b1; r.idx = (s + 1) % 32; s_dec = s;
                end
            end else if (s == 0 && body_at(st, bd, tail, 0)) begin
                r.hit = 1'b1; r.idx = 0; r.h2e = 1'b1; s_dec = s;
            end else if (st[s] == 8'h20 && body_at(st, bd, tail, s + 1)) begin
                r.hit = 1'b1; r.idx = (s + 1) % 32; r.h20 = 1'b1; s_dec = s;
            end
        end
    endtask

    task automatic send_str(input bq_t s);
        foreach (s[i]) begin
            bus.isstring = 1'b1;
            bus.chardata = s[i];
            @(posedge clk); #1;
        end
        bus.isstring = 1'b0;
        cur_str = s;
    endtask

    task automatic send_pat(input bq_t p, input bit expect_pulse);
        bit   star;
        exp_t r;
        int   s_dec;
        foreach (p[i]) begin
            bus.ispattern = 1'b1;
            bus.chardata  = p[i];
            @(posedge clk); #1;
        end
        bus.ispattern = 1'b0;
        model(cur_str, p, star, r, s_dec);
        n_chk++;
        if (bus.star_pat !== star) begin
            n_err++;
            $display("FAIL star_pat: got %0b want %0b", bus.star_pat, star);
        end
        // strobes drop now; SCAN entered next edge; candidate s decided the edge after s more
        r.cyc = cyc + s_dec + 2;
        if (expect_pulse && !star) exp_q.push_back(r);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pulse_timeout: got no pulse after %0d cycles, want %0d pending", n, exp_q.size());
            exp_q.delete();
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({bus.match_v, bus.m_done, bus.m_idx, bus.head20, bus.head2e, bus.star_pat} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got mv=%0b md=%0b idx=%0d h20=%0b h2e=%0b star=%0b, want all 0",
                     bus.match_v, bus.m_done, bus.m_idx, bus.head20, bus.head2e, bus.star_pat);
        end
        hold_idx = 5'd0; hold_h20 = 1'b0; hold_h2e = 1'b0;
        exp_q.delete();
        cur_str.delete();
        rst = 1'b0;
    endtask

    // Monitor: pops on each pulse, otherwise checks held result fields
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.match_v || bus.m_done) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: got mv=%0b md=%0b idx=%0d at cyc %0d, want none",
                             bus.match_v, bus.m_done, bus.m_idx, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.match_v !== e.hit || bus.m_done !== !e.hit || int'(bus.m_idx) != e.idx ||
                        bus.head20 !== e.h20 || bus.head2e !== e.h2e || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL pulse: got mv=%0b md=%0b idx=%0d h20=%0b h2e=%0b cyc=%0d, want hit=%0b idx=%0d h20=%0b h2e=%0b cyc=%0d",
                                 bus.match_v, bus.m_done, bus.m_idx, bus.head20, bus.head2e, cyc,
                                 e.hit, e.idx, e.h20, e.h2e, e.cyc);
                    end
                    hold_idx = 5'(e.idx); hold_h20 = e.h20; hold_h2e = e.h2e;
                end
            end else begin
                n_chk++;
                if (bus.m_idx !== hold_idx || bus.head20 !== hold_h20 || bus.head2e !== hold_h2e) begin
                    n_err++;
                    $display("FAIL hold: got idx=%0d h20=%0b h2e=%0b, want idx=%0d h20=%0b h2e=%0b",
                             bus.m_idx, bus.head20, bus.head2e, hold_idx, hold_h20, hold_h2e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        string pats[$];
        bq_t   s;
        bq_t   p;
        int    len;
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
        bus.chardata  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Directed patterns on "hello world"
        send_str(s2q("hello world"));
        pats = '{"wor", "^wor", "^hel", "l.d$", "r.d$", "xyz", "h*o", "^", "$", "^$", "o w", "^ w", "d$", "ab.d"};
        foreach (pats[i]) begin
            send_pat(s2q(pats[i]), 1'b1);
            wait_idle();
        end

        // isstring mid-scan aborts with no pulse
        send_pat(s2q("xyz"), 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        send_str(s2q("hello world"));
        repeat (15) begin @(posedge clk); #1; end

        // ispattern mid-scan restarts on the new pattern
        send_pat(s2q("xyz"), 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        send_pat(s2q("wor"), 1'b1);
        wait_idle();

        // rst mid-scan, then an empty string gives an immediate m_done
        send_pat(s2q("xyz"), 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        do_reset();
        send_pat(s2q("a"), 1'b1);
        wait_idle();

        // 32-char string, match at the last candidate wraps m_idx to 0
        s.delete();
        for (int i = 0; i < 31; i++) s.push_back(8'h61);
        s.push_back(8'h5A);
        send_str(s);
        send_pat(s2q("Z"), 1'b1);
        wait_idle();
        send_pat(s2q("aZ$"), 1'b1);
        wait_idle();

        // Randomized strings/patterns over a small alphabet
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(1, 0) == 1 || cur_str.size() == 0) begin
                s.delete();
                len = $urandom_range(34, 1);
                for (int i = 0; i < len; i++) begin
                    case ($urandom_range(2, 0))
                        0: s.push_back(8'h61);
                        1: s.push_back(8'h62);
                        default: s.push_back(8'h20);
                    endcase
                end
                send_str(s);
            end
            p.delete();
            if ($urandom_range(1, 0) == 1) p.push_back(8'h5E);
            len = $urandom_range(4, 0);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(9, 0))
                    0, 1, 2: p.push_back(8'h61);
                    3, 4, 5: p.push_back(8'h62);
                    6: p.push_back(8'h20);
                    7, 8: p.push_back(8'h2E);
                    default: p.push_back(($urandom_range(3, 0) == 0) ? 8'h2A : 8'h61);
                endcase
            end
            if ($urandom_range(2, 0) == 0) p.push_back(8'h24);
            if ($urandom_range(7, 0) == 0) begin
                while (p.size() < 10) p.push_back(8'h2E);
            end
            if (p.size() == 0) p.push_back(8'h2E);
            send_pat(p, 1'b1);
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
